// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: PC width, memory sizing,
// reset PC, NOP encoding and the prefetch queue entry layout.
// The optional misaligned-redirect check is enabled with FETCH_ALIGN_CHECK_EN.
package inst_fetch_unit_pkg;

    localparam int          PC_W         = 32;
    localparam int          ADDR_W_DEF   = 8;
    localparam int          MEM_SIZE     = 2 ** ADDR_W_DEF;
    localparam int          FQ_DEPTH_DEF = 2;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    // One prefetch queue slot: the byte PC and the instruction fetched there.
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
    } fq_entry_t;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-to-decode handshake: head {pc, inst} offered with out_vld, taken on out_rdy.
interface inst_fetch_unit_if;

    logic        out_vld;
    logic        out_rdy;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    modport master (output out_vld, output out_inst, output out_pc, input out_rdy);
    modport slave  (input out_vld, input out_inst, input out_pc, output out_rdy);

endinterface

// File: rtl/inst_fetch_unit_fetch_queue.sv
// Prefetch queue: synchronous FIFO of {pc, inst} entries with wrap-bit pointers.
// Flush empties it in one cycle; push and pop together when full keep it full.
module inst_fetch_unit_fetch_queue
    import inst_fetch_unit_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  fq_entry_t tail,
    output logic      full,
    output logic      empty,
    output fq_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);

    fq_entry_t        slots [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers equal means empty; same slot with differing wrap bit means full.
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        head    = slots[rd_ptr[PTR_W-1:0]];
    end

    // Pointer update; flush discards everything and overrides push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Slot storage; when full the pushed entry reuses the slot being popped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
        end else if (do_push && !flush) begin
            slots[wr_ptr[PTR_W-1:0]] <= tail;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads the combinational
// instruction memory, buffers results in the prefetch queue and applies
// redirects from execute. Define FETCH_ALIGN_CHECK_EN to flag and halt on
// misaligned redirect targets; otherwise their low two bits are ignored.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int          FQ_DEPTH = FQ_DEPTH_DEF,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [31:0]         imem_data,
    input  logic                redirect_vld,
    input  logic [31:0]         redirect_pc,
    inst_fetch_unit_if.master   out_bus,
    output logic                misalign_err
);

    logic [PC_W-1:0] fetch_pc;
    logic            halted;
    logic            out_clear;
    logic            push;
    logic            pop;
    logic            fq_full;
    logic            fq_empty;
    fq_entry_t       fq_head;
    fq_entry_t       fq_tail;

`ifdef FETCH_ALIGN_CHECK_EN
    // A misaligned redirect target stops fetch until an aligned redirect arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              halted <= 1'b0;
        else if (redirect_vld) halted <= (redirect_pc[1:0] != 2'b00);
    end
    assign misalign_err = halted;
`else
    assign halted       = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // Handshake decode; a redirect squashes the pop and blocks the push.
    always_comb begin
        pop       = out_bus.out_vld && out_bus.out_rdy && !redirect_vld;
        push      = (!fq_full || pop) && !redirect_vld && !halted;
        imem_addr = fetch_pc[ADDR_W+1:2];
        fq_tail   = '{pc: fetch_pc, inst: imem_data};
    end

    // Fetch PC: a redirect always wins, otherwise advance one word per push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              fetch_pc <= align_pc(RESET_PC);
        else if (redirect_vld) fetch_pc <= align_pc(redirect_pc);
        else if (push)         fetch_pc <= fetch_pc + 32'd4;
    end

    // Outputs read zero straight out of reset until the first clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) out_clear <= 1'b1;
        else      out_clear <= 1'b0;
    end

    inst_fetch_unit_fetch_queue #(.DEPTH(FQ_DEPTH)) u_fetch_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_vld),
        .tail  (fq_tail),
        .full  (fq_full),
        .empty (fq_empty),
        .head  (fq_head)
    );

    // Present the queue head; an empty queue shows a NOP at pc 0.
    always_comb begin
        out_bus.out_vld = !fq_empty;
        if (out_clear) begin
            out_bus.out_inst = '0;
            out_bus.out_pc   = '0;
        end else if (fq_empty) begin
            out_bus.out_inst = NOP_INST;
            out_bus.out_pc   = '0;
        end else begin
            out_bus.out_inst = fq_head.inst;
            out_bus.out_pc   = fq_head.pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit against a queue-based reference
// model. Honours FETCH_ALIGN_CHECK_EN the same way the design does.
module tb_inst_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_vld = 1'b0;
    logic [31:0] redirect_pc  = '0;
    logic        misalign_err;

    logic [31:0] mem [256];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    ent_t        mq[$];
    logic [31:0] mpc;
    logic        mhalt;
    logic        mfresh;

    inst_fetch_unit_if bus ();

    inst_fetch_unit #(.ADDR_W(8), .FQ_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .out_bus      (bus.master),
        .misalign_err (misalign_err)
    );

    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare every observable output with the model's view of this cycle.
    task automatic checkState();
        checkOutput("out_vld", 64'(bus.out_vld), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            checkOutput("out_pc", 64'(bus.out_pc), 64'(mq[0].pc));
            checkOutput("out_inst", 64'(bus.out_inst), 64'(mq[0].inst));
        end else begin
            checkOutput("empty_inst", 64'(bus.out_inst), mfresh ? 64'h0 : 64'(NOP));
        end
        checkOutput("imem_addr", 64'(imem_addr), 64'(mpc[9:2]));
        checkOutput("misalign_err", 64'(misalign_err), 64'(mhalt));
    endtask

    // Called at a falling edge: check, drive, advance the model, next falling edge.
    task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rpc);
        logic do_pop;
        logic do_push;
        checkState();
        bus.out_rdy  = rdy;
        redirect_vld = rv;
        redirect_pc  = rpc;
        mfresh = 1'b0;
        if (rv) begin
            mq.delete();
`ifdef FETCH_ALIGN_CHECK_EN
            mhalt = (rpc[1:0] != 2'b00);
`endif
            mpc = {rpc[31:2], 2'b00};
        end else begin
            do_pop  = (mq.size() != 0) && rdy;
            do_push = ((mq.size() < DEPTH) || do_pop) && !mhalt;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back('{pc: mpc, inst: mem[mpc[9:2]]});
                mpc = mpc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    // Assert reset between edges; outputs must clear without waiting for a clock.
    task automatic doReset();
        #2;
        rst = 1'b0;
        redirect_vld = 1'b0;
        #1;
        checkOutput("rst_out_vld", 64'(bus.out_vld), 64'h0);
        checkOutput("rst_out_pc", 64'(bus.out_pc), 64'h0);
        checkOutput("rst_out_inst", 64'(bus.out_inst), 64'h0);
        checkOutput("rst_misalign", 64'(misalign_err), 64'h0);
        checkOutput("rst_imem_addr", 64'(imem_addr), 64'h0);
        mq.delete();
        mpc    = 32'h0;
        mhalt  = 1'b0;
        mfresh = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        bus.out_rdy = 1'b0;
        @(negedge clk);
        doReset();

        $display("[TB] streaming from reset");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'h0);

        $display("[TB] decode stall");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'h0);

        $display("[TB] redirect while full");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h14);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0);

        $display("[TB] memory wrap");
        applyStimulus(1'b1, 1'b1, 32'h3FC);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'h0);

        $display("[TB] back-to-back redirects");
        applyStimulus(1'b1, 1'b1, 32'h40);
        applyStimulus(1'b1, 1'b1, 32'h80);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0);

        $display("[TB] reset mid-stream");
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0);

        $display("[TB] misaligned redirect");
        applyStimulus(1'b1, 1'b1, 32'h16);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h18);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            logic        rdy;
            logic        rv;
            logic [31:0] rpc;
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       rpc = $urandom;
                1:       rpc = 32'h3F0 + 32'($urandom_range(0, 15));
                default: rpc = 32'($urandom_range(0, 1023));
            endcase
            applyStimulus(rdy, rv, rpc);
        end
        checkState();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
